// File: rtl/clk_div_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_meter
//  Description : Measures high time, low time and period of an asynchronous
//                divided clock in clk cycles. Flags a stable period (locked)
//                and a stalled input (timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_meter #(
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 4,
  parameter int TOL    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_in,
  output logic [CNT_W-1:0] half_hi,
  output logic [CNT_W-1:0] half_lo,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - 1'b1;
  localparam logic [3:0]       MATCH_MAX = 4'(LOCK_N);
  localparam logic [3:0]       MATCH_THR = 4'(LOCK_N - 1);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HI   = 2'd2,
    MEAS_LO   = 2'd3
  } state_t;

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise_w, fall_w, edge_w, sat_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q;
  logic [CNT_W-1:0] hi_q, lo_q;
  logic             pend_q;
  logic             timeout_q;
  logic [CNT_W-1:0] half_hi_q, half_lo_q;
  logic [CNT_W:0]   period_q, prev_q;
  logic             meas_valid_q, locked_q, ref_q;
  logic [3:0]       match_q, match_d;
  logic [CNT_W:0]   per_w, diff_w;

  // Two-flop synchronizer plus a third copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= f_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_w = sync2_q & ~sync3_q;
  assign fall_w = ~sync2_q & sync3_q;
  assign edge_w = rise_w | fall_w;
  // Counter is about to saturate and no edge rescues it this cycle
  assign sat_w  = ~edge_w & (cnt_q == CNT_PRE);

  // Interval counter: restart at 1 on each detect cycle, saturate otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (edge_w) begin
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Measurement FSM: captures hi/lo intervals and flags a pending publish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pend_q <= 1'b0;
      if (edge_w) begin
        timeout_q <= 1'b0;
        case (state_q)
          IDLE:      state_q <= rise_w ? MEAS_HI : WAIT_RISE;
          WAIT_RISE: if (rise_w) state_q <= MEAS_HI;
          MEAS_HI: begin
            if (fall_w) begin
              hi_q    <= cnt_q;
              state_q <= MEAS_LO;
            end
          end
          MEAS_LO: begin
            if (rise_w) begin
              lo_q    <= cnt_q;
              pend_q  <= 1'b1;
              state_q <= MEAS_HI;
            end
          end
          default:   state_q <= IDLE;
        endcase
      end else if (sat_w) begin
        timeout_q <= 1'b1;
        state_q   <= IDLE;
      end
    end
  end

  assign per_w  = {1'b0, hi_q} + {1'b0, lo_q};
  assign diff_w = (per_w >= prev_q) ? (per_w - prev_q) : (prev_q - per_w);

  // Match count that the next publish will store
  always_comb begin
    match_d = 4'd0;
    if (ref_q && (diff_w <= TOL_V)) begin
      match_d = (match_q == MATCH_MAX) ? match_q : match_q + 4'd1;
    end
  end

  // Publish results one cycle after the closing rise and update lock state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_hi_q    <= '0;
      half_lo_q    <= '0;
      period_q     <= '0;
      prev_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      ref_q        <= 1'b0;
      match_q      <= 4'd0;
    end else begin
      meas_valid_q <= pend_q;
      if (sat_w) begin
        locked_q <= 1'b0;
        match_q  <= 4'd0;
        ref_q    <= 1'b0;
      end else if (pend_q) begin
        half_hi_q <= hi_q;
        half_lo_q <= lo_q;
        period_q  <= per_w;
        prev_q    <= per_w;
        ref_q     <= 1'b1;
        match_q   <= match_d;
        locked_q  <= (match_d >= MATCH_THR);
      end
    end
  end

  assign half_hi    = half_hi_q;
  assign half_lo    = half_lo_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_meter
//  Description : Self-checking bench for clk_div_meter. An event-level model
//                predicts every published measurement from the toggle times
//                the bench drives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_meter;
  localparam int CW   = 4;
  localparam int LN   = 4;
  localparam int TL   = 1;
  localparam int MAXC = (1 << CW) - 1;
  // Toggle to detect takes 3 cycles, publish is one more registered cycle
  localparam int LAT  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          f_in = 1'b0;
  logic [CW-1:0] half_hi, half_lo;
  logic [CW:0]   period;
  logic          meas_valid, locked, timeout;

  clk_div_meter #(.CNT_W(CW), .LOCK_N(LN), .TOL(TL)) dut (
    .clk(clk), .reset(reset), .f_in(f_in),
    .half_hi(half_hi), .half_lo(half_lo), .period(period),
    .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int          t;
    logic [CW-1:0] hi;
    logic [CW-1:0] lo;
    logic [CW:0]   per;
    logic          lk;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  rec_t mon_r;

  // Record every observed publish
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mon_r.t   = cyc;
      mon_r.hi  = half_hi;
      mon_r.lo  = half_lo;
      mon_r.per = period;
      mon_r.lk  = locked;
      obs_q.push_back(mon_r);
    end
  end

  // ---------------- reference model (event level) ----------------
  int   m_last_t, m_nedge, m_rise_t, m_fall_t, m_prev, m_match;
  bit   m_ref;
  int   m_hi, m_lo, m_per;

  // Reset release at cycle r: counter behaves as if an edge toggled at r-2
  task automatic model_reset(input int r);
    m_last_t = r - 2;
    m_nedge  = 0;
    m_ref    = 0;
    m_match  = 0;
  endtask

  task automatic model_edge(input int t, input logic lvl);
    int   d;
    rec_t e;
    if (t - m_last_t >= MAXC) begin
      m_nedge = 0;
      m_ref   = 0;
      m_match = 0;
    end
    m_nedge++;
    m_last_t = t;
    if (lvl) begin
      if (m_nedge >= 3) begin
        m_hi  = m_fall_t - m_rise_t;
        m_lo  = t - m_fall_t;
        m_per = m_hi + m_lo;
        d = m_per - m_prev;
        if (d < 0) d = -d;
        if (!m_ref)       m_match = 0;
        else if (d <= TL) m_match = (m_match < LN) ? m_match + 1 : LN;
        else              m_match = 0;
        m_ref  = 1;
        m_prev = m_per;
        e.t   = t + LAT;
        e.hi  = CW'(m_hi);
        e.lo  = CW'(m_lo);
        e.per = (CW + 1)'(m_per);
        e.lk  = (m_match >= LN - 1);
        exp_q.push_back(e);
      end
      m_rise_t = t;
    end else begin
      m_fall_t = t;
    end
  endtask

  // Drive lvl starting right after the next edge and keep it for n cycles
  task automatic drive_half(input logic lvl, input int n);
    @(posedge clk);
    #1;
    if (f_in !== lvl) begin
      f_in = lvl;
      model_edge(cyc, lvl);
    end
    repeat (n - 1) @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rec_t o, e;
    reset = 1'b0;
    f_in  = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 f_in = ~f_in;
      @(negedge clk);
      checks++;
      if ({half_hi, half_lo, period, meas_valid, locked, timeout} !== '0) begin
        errors++;
        $display("FAIL reset_hold got hi=%0d lo=%0d per=%0d mv=%b lk=%b to=%b want all 0",
                 half_hi, half_lo, period, meas_valid, locked, timeout);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset(cyc);
    for (int i = 0; i < 3; i++) begin
      drive_half(1'b1, 4);
      drive_half(1'b0, 4);
    end
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_pulse got t=%0d hi=%0d lo=%0d per=%0d lk=%b want t=%0d hi=%0d lo=%0d per=%0d lk=%b",
                 o.t, o.hi, o.lo, o.per, o.lk, e.t, e.hi, e.lo, e.per, e.lk);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_symmetric();
    rec_t o, e;
    for (int i = 0; i < 8; i++) begin
      drive_half(1'b1, 3);
      drive_half(1'b0, 3);
    end
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (half_hi !== 4'd3 || half_lo !== 4'd3 || period !== 5'd6 || locked !== 1'b1) begin
      errors++;
      $display("FAIL sym_final got hi=%0d lo=%0d per=%0d lk=%b want hi=3 lo=3 per=6 lk=1",
               half_hi, half_lo, period, locked);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sym_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sym_pulse got t=%0d hi=%0d lo=%0d per=%0d lk=%b want t=%0d hi=%0d lo=%0d per=%0d lk=%b",
                 o.t, o.hi, o.lo, o.per, o.lk, e.t, e.hi, e.lo, e.per, e.lk);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_asymmetric();
    rec_t o, e;
    for (int i = 0; i < 8; i++) begin
      drive_half(1'b1, 2);
      drive_half(1'b0, 5);
    end
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (half_hi !== 4'd2 || half_lo !== 4'd5 || period !== 5'd7 || locked !== 1'b1) begin
      errors++;
      $display("FAIL asym_final got hi=%0d lo=%0d per=%0d lk=%b want hi=2 lo=5 per=7 lk=1",
               half_hi, half_lo, period, locked);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL asym_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL asym_pulse got t=%0d hi=%0d lo=%0d per=%0d lk=%b want t=%0d hi=%0d lo=%0d per=%0d lk=%b",
                 o.t, o.hi, o.lo, o.per, o.lk, e.t, e.hi, e.lo, e.per, e.lk);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_ratio_change();
    rec_t o, e;
    for (int i = 0; i < 6; i++) begin
      drive_half(1'b1, 3);
      drive_half(1'b0, 3);
    end
    for (int i = 0; i < 5; i++) begin
      drive_half(1'b1, 5);
      drive_half(1'b0, 5);
    end
    for (int i = 0; i < 6; i++) begin
      drive_half(1'b1, 3);
      drive_half(1'b0, 3);
    end
    for (int i = 0; i < 3; i++) begin
      drive_half(1'b1, 3);
      drive_half(1'b0, 4);
    end
    drive_half(1'b1, 3);
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (period !== 5'd7 || locked !== 1'b1) begin
      errors++;
      $display("FAIL ratio_final got per=%0d lk=%b want per=7 lk=1", period, locked);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ratio_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ratio_pulse got t=%0d hi=%0d lo=%0d per=%0d lk=%b want t=%0d hi=%0d lo=%0d per=%0d lk=%b",
                 o.t, o.hi, o.lo, o.per, o.lk, e.t, e.hi, e.lo, e.per, e.lk);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    rec_t o, e;
    int   t0, t1;
    // A 14-cycle gap is the longest that must not time out
    drive_half(1'b0, 3);
    drive_half(1'b1, 3);
    drive_half(1'b0, 14);
    drive_half(1'b1, 3);
    drive_half(1'b0, 3);
    drive_half(1'b1, 3);
    drive_half(1'b0, 1);
    t0 = m_last_t;
    @(negedge clk);
    while (cyc < t0 + 16) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got to=%b want 0 at cycle %0d", timeout, cyc);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_set got to=%b lk=%b want to=1 lk=0", timeout, locked);
    end
    checks++;
    if (half_hi !== CW'(m_hi) || half_lo !== CW'(m_lo) || period !== (CW + 1)'(m_per)) begin
      errors++;
      $display("FAIL timeout_hold got hi=%0d lo=%0d per=%0d want hi=%0d lo=%0d per=%0d",
               half_hi, half_lo, period, m_hi, m_lo, m_per);
    end
    while (cyc < t0 + 24) @(negedge clk);
    @(posedge clk);
    #1 f_in = 1'b1;
    t1 = cyc;
    model_edge(t1, 1'b1);
    while (cyc < t1 + 2) @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_before_edge got to=%b want 1", timeout);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got to=%b want 0", timeout);
    end
    for (int i = 0; i < 3; i++) begin
      drive_half(1'b0, 3);
      drive_half(1'b1, 3);
    end
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout_pulse got t=%0d hi=%0d lo=%0d per=%0d lk=%b want t=%0d hi=%0d lo=%0d per=%0d lk=%b",
                 o.t, o.hi, o.lo, o.per, o.lk, e.t, e.hi, e.lo, e.per, e.lk);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    rec_t o, e;
    for (int i = 0; i < 3; i++) begin
      drive_half(1'b1, 3);
      drive_half(1'b0, 5);
    end
    drive_half(1'b1, 3);
    drive_half(1'b0, 4);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({half_hi, half_lo, period, meas_valid, locked, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear got hi=%0d lo=%0d per=%0d mv=%b lk=%b to=%b want all 0",
               half_hi, half_lo, period, meas_valid, locked, timeout);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset(cyc);
    for (int i = 0; i < 3; i++) begin
      drive_half(1'b1, 3);
      drive_half(1'b0, 3);
    end
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_pulse got t=%0d hi=%0d lo=%0d per=%0d lk=%b want t=%0d hi=%0d lo=%0d per=%0d lk=%b",
                 o.t, o.hi, o.lo, o.per, o.lk, e.t, e.hi, e.lo, e.per, e.lk);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    rec_t o, e;
    int   hi, lo, lj;
    hi = 3;
    lo = 4;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        hi = $urandom_range(1, 7);
        lo = $urandom_range(1, 7);
      end
      lj = lo + $urandom_range(0, 2) - 1;
      if (lj < 1) lj = 1;
      drive_half(1'b1, hi);
      drive_half(1'b0, lj);
    end
    drive_half(1'b1, 2);
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_pulse got t=%0d hi=%0d lo=%0d per=%0d lk=%b want t=%0d hi=%0d lo=%0d per=%0d lk=%b",
                 o.t, o.hi, o.lo, o.per, o.lk, e.t, e.hi, e.lo, e.per, e.lk);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    m_last_t = 0; m_nedge = 0; m_rise_t = 0; m_fall_t = 0;
    m_prev = 0; m_match = 0; m_ref = 0; m_hi = 0; m_lo = 0; m_per = 0;
    test_reset();
    test_symmetric();
    test_asymmetric();
    test_ratio_change();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
